// File: rtl/dmem_responder.sv
// Single-port data memory slave: captures one request per MREQ/WRITE assertion,
// inserts WAIT_CYCLES wait states, then acknowledges for one cycle with error status.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  input  logic [31:0] DAD,
  inout  tri   [31:0] DDT,
  output logic        ACKD_n,
  output logic        ERR
);

  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           wr_q, wr_d;
  logic [1:0]     size_q, size_d;
  logic [IW+1:0]  addr_q, addr_d;
  logic [31:0]    data_q, data_d;
  logic           ack_n_q, ack_n_d;
  logic           err_q, err_d;
  logic           drv_q, drv_d;
  logic [31:0]    rd_word_q;
  logic [31:0]    mem [DEPTH_WORDS];

  logic           req_s;
  logic           enter_ack_s;
  logic           txn_err_s;
  logic           we_s;
  logic           re_s;
  logic [3:0]     be_s;
  logic [31:0]    wdata_s;
  logic [31:0]    rd_data_s;
  logic [IW-1:0]  widx_s;
  logic           unused_dad_s;

  function automatic logic access_error(input logic [1:0] size, input logic [1:0] a);
    logic e;
    case (size)
      2'b00:   e = 1'b0;
      2'b01:   e = a[0];
      2'b10:   e = (a != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << a;
      2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] align_read(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] a);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {a, 3'b000};
    case (size)
      2'b00:   r = {24'h000000, sh[7:0]};
      2'b01:   r = {16'h0000, sh[15:0]};
      2'b10:   r = word;
      default: r = 32'h00000000;
    endcase
    return r;
  endfunction

  assign req_s        = MREQ | WRITE;
  assign unused_dad_s = ^DAD[31:IW+2];

  // Next state; in IDLE the *_d fields carry the live inputs so they are captured at E0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          wr_d    = WRITE;
          size_d  = SIZE;
          addr_d  = DAD[IW+1:0];
          data_d  = DDT;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_CYCLES > 0) ? WAIT : ACK;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (req_s) begin
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Work done on the edge that enters ACK: memory access and next output values.
  always_comb begin
    enter_ack_s = (state_d == ACK);
    txn_err_s   = access_error(size_d, addr_d[1:0]);
    be_s        = txn_err_s ? 4'b0000 : lane_mask(size_d, addr_d[1:0]);
    wdata_s     = data_d << {addr_d[1:0], 3'b000};
    widx_s      = addr_d[IW+1:2];
    we_s        = rst & enter_ack_s & wr_d & ~txn_err_s;
    re_s        = rst & enter_ack_s & ~wr_d;
    ack_n_d     = ~enter_ack_s;
    err_d       = enter_ack_s & txn_err_s;
    drv_d       = enter_ack_s & ~wr_d;
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack_n_q <= 1'b1;
      err_q   <= 1'b0;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_n_q <= ack_n_d;
      err_q   <= err_d;
      drv_q   <= drv_d;
    end
  end

  // Captured request; only consulted after a capture, so it needs no reset.
  always_ff @(posedge clk) begin
    wr_q   <= wr_d;
    size_q <= size_d;
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Storage: byte-enabled write and registered read on a single address port.
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem[widx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
    if (re_s) begin
      rd_word_q <= mem[widx_s];
    end
  end

  assign rd_data_s = err_q ? 32'h00000000 : align_read(rd_word_q, size_q, addr_q[1:0]);
  assign DDT       = drv_q ? rd_data_s : {32{1'bz}};
  assign ACKD_n    = ack_n_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) share stimulus and are
// checked every cycle against a byte-array memory model and a spec-level ack schedule.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int NB    = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mreq = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] dad = 32'h0;
  logic        tb_oe = 1'b0;
  logic [31:0] tb_data = 32'h0;
  logic [1:0]  ack_n_v;
  logic [1:0]  err_v;
  tri   [31:0] ddt0;
  tri   [31:0] ddt1;

  assign ddt0 = tb_oe ? tb_data : {32{1'bz}};
  assign ddt1 = tb_oe ? tb_data : {32{1'bz}};

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .MREQ(mreq), .WRITE(write), .SIZE(size), .DAD(dad),
    .DDT(ddt0), .ACKD_n(ack_n_v[0]), .ERR(err_v[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .MREQ(mreq), .WRITE(write), .SIZE(size), .DAD(dad),
    .DDT(ddt1), .ACKD_n(ack_n_v[1]), .ERR(err_v[1]));

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          started = 1'b0;
  int          ready_cyc = 0;
  int          t_e0 = -100;
  bit          t_valid [2];
  bit          t_wr;
  logic [1:0]  t_sz;
  logic [31:0] t_a;
  logic [31:0] t_d;
  logic [31:0] last_rd [2];
  logic        last_err [2];
  int          ack_seen [2];
  logic [7:0]  mem_m [2][NB];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01 && a[0]) return 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] r;
    int base;
    r = 32'h0;
    if (model_err(sz, a)) return r;
    base = int'(a & 32'(NB - 1));
    for (int i = 0; i < nbytes(sz); i++) r[8*i +: 8] = mem_m[d][(base + i) % NB];
    return r;
  endfunction

  task automatic model_write(input int d, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] v);
    int base;
    base = int'(a & 32'(NB - 1));
    for (int i = 0; i < nbytes(sz); i++) mem_m[d][(base + i) % NB] = v[8*i +: 8];
  endtask

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h expected=%h", name, d, cyc, act, exp);
    end
  endtask

  // Per-cycle compare: ack/err schedule, read data, and bus release.
  logic [31:0] bus;
  bit          exp_ack;
  bit          exp_err;
  always begin
    @(negedge clk);
    #1;
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        bus     = (d == 0) ? ddt0 : ddt1;
        exp_ack = t_valid[d] && (cyc == t_e0 + wait_of(d));
        exp_err = exp_ack && model_err(t_sz, t_a);
        if (ack_n_v[d] == 1'b0) ack_seen[d]++;
        check("ackd_n", d, 32'(ack_n_v[d]), 32'(!exp_ack));
        check("err", d, 32'(err_v[d]), 32'(exp_err));
        if (exp_ack) last_err[d] = err_v[d];
        if (exp_ack && t_wr && !exp_err) model_write(d, t_sz, t_a, t_d);
        if (exp_ack && !t_wr) begin
          check("rdata", d, bus, model_read(d, t_sz, t_a));
          last_rd[d] = bus;
        end else if (!tb_oe) begin
          check("ddt_release", d, (bus === {32{1'bz}}) ? 32'h0 : bus, 32'h0);
        end
      end
    end
  end

  task automatic scramble();
    dad     = $urandom;
    size    = 2'($urandom_range(3, 0));
    tb_data = $urandom;
  endtask

  task automatic issue(input bit wr, input bit both, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] dat, input int hold, input int extra);
    while (cyc < ready_cyc) @(negedge clk);
    mreq = ~wr | both;
    write = wr;
    size = sz;
    dad = a;
    tb_data = dat;
    tb_oe = wr;
    t_e0 = cyc + 1;
    t_valid[0] = 1'b1;
    t_valid[1] = 1'b1;
    t_wr = wr;
    t_sz = sz;
    t_a = a;
    t_d = dat;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      scramble();
    end
    @(negedge clk);
    mreq = 1'b0;
    write = 1'b0;
    tb_oe = 1'b0;
    scramble();
    ready_cyc = ((hold + 1 > 4) ? t_e0 + hold + 1 : t_e0 + 4) + extra;
  endtask

  task automatic drain();
    while (cyc < ready_cyc) @(negedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int a0;
    int a1;
    bit wr;
    logic [1:0] sz;
    logic [31:0] a;

    repeat (3) @(negedge clk);
    started = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    ready_cyc = cyc;

    for (int i = 0; i < 16; i++)
      issue(1'b1, 1'b0, 2'b10, 32'(4 * i), 32'h10203040 + 32'(i) * 32'h01010101, 0, 0);

    // Word write then read, with MREQ also high on the write.
    issue(1'b1, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 0, 0);
    issue(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 0, 0);
    drain();
    check("model_pin_deadbeef", 0, model_read(0, 2'b10, 32'h10), 32'hDEADBEEF);
    check("word_rd_deadbeef", 0, last_rd[0], 32'hDEADBEEF);
    check("word_rd_deadbeef", 1, last_rd[1], 32'hDEADBEEF);
    check("word_rd_noerr", 0, 32'(last_err[0]), 32'h0);

    // Byte lane merge.
    issue(1'b1, 1'b0, 2'b10, 32'h10, 32'h11223344, 0, 0);
    issue(1'b1, 1'b0, 2'b00, 32'h13, 32'h123456A5, 1, 0);
    issue(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 0, 1);
    drain();
    check("merge_word", 0, last_rd[0], 32'hA5223344);
    check("merge_word", 1, last_rd[1], 32'hA5223344);
    issue(1'b0, 1'b0, 2'b00, 32'h13, 32'h0, 0, 0);
    drain();
    check("model_pin_byte", 0, model_read(0, 2'b00, 32'h13), 32'h000000A5);
    check("byte_rd", 0, last_rd[0], 32'h000000A5);
    issue(1'b0, 1'b0, 2'b01, 32'h12, 32'h0, 0, 0);
    drain();
    check("half_rd_upper", 0, last_rd[0], 32'h0000A522);

    // Error cases leave storage unchanged.
    issue(1'b0, 1'b0, 2'b01, 32'h11, 32'h0, 0, 0);
    drain();
    check("err_half_mis", 0, 32'(last_err[0]), 32'h1);
    check("err_half_mis", 1, 32'(last_err[1]), 32'h1);
    check("err_half_data", 0, last_rd[0], 32'h0);
    issue(1'b1, 1'b0, 2'b10, 32'h12, 32'hFFFFFFFF, 0, 0);
    drain();
    check("err_word_mis_wr", 0, 32'(last_err[0]), 32'h1);
    issue(1'b0, 1'b0, 2'b11, 32'h10, 32'h0, 0, 0);
    drain();
    check("err_size11", 0, 32'(last_err[0]), 32'h1);
    check("err_size11_data", 0, last_rd[0], 32'h0);
    issue(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 0, 0);
    drain();
    check("err_no_update", 0, last_rd[0], 32'hA5223344);
    check("err_no_update", 1, last_rd[1], 32'hA5223344);

    // Held request gives one ack; re-accepted after one low cycle.
    a0 = ack_seen[0];
    a1 = ack_seen[1];
    issue(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 10, 0);
    issue(1'b0, 1'b0, 2'b10, 32'h14, 32'h0, 0, 0);
    drain();
    check("held_one_ack", 0, 32'(ack_seen[0] - a0), 32'd2);
    check("held_one_ack", 1, 32'(ack_seen[1] - a1), 32'd2);

    // Reset during WAIT of a write aborts it on the 2-wait instance.
    issue(1'b1, 1'b0, 2'b10, 32'h20, 32'h20202020, 0, 0);
    while (cyc < ready_cyc) @(negedge clk);
    write = 1'b1;
    mreq = 1'b0;
    size = 2'b10;
    dad = 32'h20;
    tb_data = 32'h5555AAAA;
    tb_oe = 1'b1;
    t_e0 = cyc + 1;
    t_valid[0] = 1'b1;
    t_valid[1] = 1'b1;
    t_wr = 1'b1;
    t_sz = 2'b10;
    t_a = 32'h20;
    t_d = 32'h5555AAAA;
    @(negedge clk);
    write = 1'b0;
    tb_oe = 1'b0;
    rst = 1'b0;
    t_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ready_cyc = cyc;
    issue(1'b0, 1'b0, 2'b10, 32'h20, 32'h0, 0, 0);
    drain();
    check("rst_abort_keep", 0, last_rd[0], 32'h20202020);
    check("rst_after_commit", 1, last_rd[1], 32'h5555AAAA);

    // Address wrap modulo 4*DEPTH.
    issue(1'b1, 1'b0, 2'b10, 32'h1000, 32'hCAFEF00D, 0, 0);
    issue(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 0, 0);
    drain();
    check("alias_0x1000", 1, last_rd[1], 32'hCAFEF00D);
    check("alias_0x1000", 0, last_rd[0], 32'hCAFEF00D);

    for (int n = 0; n < 300; n++) begin
      wr = 1'($urandom_range(1, 0));
      sz = ($urandom_range(9, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
      a  = 32'($urandom_range(63, 0)) | (32'($urandom_range(3, 0)) << 12);
      if ($urandom_range(1, 0) == 1) a = a | 32'hA5A00000;
      if (sz == 2'b01 && $urandom_range(3, 0) != 0) a[0] = 1'b0;
      if (sz == 2'b10 && $urandom_range(3, 0) != 0) a[1:0] = 2'b00;
      issue(wr, 1'($urandom_range(1, 0)), sz, a, $urandom, $urandom_range(3, 0), $urandom_range(2, 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
